// File: rtl/slink_crc_check_pkg.sv
// Shared definitions for the S-Link receive CRC checker: FSM encoding, CRC
// constants and the reflected CRC-16/MCRF4XX byte update.
package slink_crc_check_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CRC     = 2'd2,
        ST_CRC_HI  = 2'd3
    } state_t;

    localparam logic [15:0] CRC_SEED     = 16'hFFFF;
    // 0x1021 bit-reversed: bytes enter LSB first, as on CSI/DSI links.
    localparam logic [15:0] CRC_POLY_REF = 16'h8408;

    function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in,
                                               input logic [7:0]  byte_in);
        logic [15:0] r;
        r = crc_in ^ {8'h00, byte_in};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ CRC_POLY_REF) : (r >> 1);
        end
        return r;
    endfunction

endpackage

// File: rtl/slink_crc_8_16bit_compute.sv
// CRC-16/MCRF4XX engine absorbing up to two bytes per cycle (byte0 = data[7:0]
// first). init reloads the seed and takes priority over any data.
module slink_crc_8_16bit_compute
    import slink_crc_check_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] data,
    input  logic [1:0]  valid,
    input  logic        init,
    input  logic [15:0] crc_prev,
    output logic [15:0] crc
);

    logic [15:0] crc_next;

    always_comb begin
        crc_next = crc_prev;
        if (valid[0]) crc_next = crc16_byte(crc_next, data[7:0]);
        if (valid[1]) crc_next = crc16_byte(crc_next, data[15:8]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)     crc <= CRC_SEED;
        else if (init) crc <= CRC_SEED;
        else           crc <= crc_next;
    end

endmodule

// File: rtl/slink_crc_check.sv
// Receive-side CRC-16 checker for S-Link long packets: payload bytes, then a
// 2-byte CRC field (low byte first). Define SLINK_CRC_CHECK_ERR_CNT_EN for the
// saturating crc_err_count output.
module slink_crc_check
    import slink_crc_check_pkg::*;
#(
    parameter int WC_W      = 16,
    parameter int ERR_CNT_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pkt_start,
    input  logic [WC_W-1:0] pkt_wc,
    input  logic            data_en,
    input  logic [15:0]     data_in,
    output logic            busy,
    output logic            crc_done,
    output logic            crc_err,
    output logic [15:0]     crc_calc,
    output logic [15:0]     crc_rx
`ifdef SLINK_CRC_CHECK_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0] crc_err_count
`endif
);

    state_t          state;
    logic [WC_W-1:0] rem;
    logic [7:0]      rx_lo;
    logic [15:0]     crc_reg;
    logic [1:0]      feed_valid;
    logic [15:0]     rx_field;
    logic            final_beat;
    logic            mismatch;

    // A pkt_start beat carries no data, so it never feeds the engine.
    always_comb begin
        feed_valid = 2'b00;
        if (state == ST_PAYLOAD && data_en && !pkt_start) begin
            feed_valid = (rem == WC_W'(1)) ? 2'b01 : 2'b11;
        end
        final_beat = data_en && (state == ST_CRC || state == ST_CRC_HI);
        rx_field   = (state == ST_CRC_HI) ? {data_in[7:0], rx_lo} : data_in;
        mismatch   = (crc_reg != rx_field);
    end

    slink_crc_8_16bit_compute u_crc (
        .clk      (clk),
        .reset    (reset),
        .data     (data_in),
        .valid    (feed_valid),
        .init     (pkt_start),
        .crc_prev (crc_reg),
        .crc      (crc_reg)
    );

    // A finishing CRC beat still reports even if pkt_start lands on the same
    // cycle; the later pkt_start assignments then win for busy/state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            rem      <= '0;
            rx_lo    <= '0;
            busy     <= 1'b0;
            crc_done <= 1'b0;
            crc_err  <= 1'b0;
            crc_calc <= CRC_SEED;
            crc_rx   <= '0;
        end else begin
            crc_done <= 1'b0;
            if (final_beat) begin
                crc_done <= 1'b1;
                crc_err  <= mismatch;
                crc_calc <= crc_reg;
                crc_rx   <= rx_field;
                busy     <= 1'b0;
                state    <= ST_IDLE;
            end
            if (pkt_start) begin
                rem   <= pkt_wc;
                busy  <= 1'b1;
                state <= (pkt_wc != '0) ? ST_PAYLOAD : ST_CRC;
            end else if (state == ST_PAYLOAD && data_en) begin
                if (rem > WC_W'(2)) begin
                    rem <= rem - WC_W'(2);
                end else if (rem == WC_W'(2)) begin
                    rem   <= '0;
                    state <= ST_CRC;
                end else begin
                    rem   <= '0;
                    rx_lo <= data_in[15:8];
                    state <= ST_CRC_HI;
                end
            end
        end
    end

`ifdef SLINK_CRC_CHECK_ERR_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crc_err_count <= '0;
        end else if (final_beat && mismatch && crc_err_count != '1) begin
            crc_err_count <= crc_err_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_slink_crc_check.sv
// Directed bench for slink_crc_check: table of whole packets plus hand-written
// abort, back-to-back, reset and saturation sequences.
module tb_slink_crc_check;

  logic        clk = 1'b0;
  logic        reset;
  logic        pkt_start;
  logic [15:0] pkt_wc;
  logic        data_en;
  logic [15:0] data_in;
  logic        busy;
  logic        crc_done;
  logic        crc_err;
  logic [15:0] crc_calc;
  logic [15:0] crc_rx;
`ifdef SLINK_CRC_CHECK_ERR_CNT_EN
  logic [7:0]  crc_err_count;
  int          exp_cnt = 0;
`endif

  int n_vec = 0;
  int n_bad = 0;

  logic [32:0] exp_q[$];

  typedef struct {
    int          wc;
    logic [15:0] field;
    logic        stall;
    logic        exp_err;
    logic [15:0] exp_calc;
  } vec_t;

  vec_t vecs[10];

  logic [7:0] pay [24] = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h1E, 8'hF0, 8'h1E, 8'hC7,
                           8'h4F, 8'h82, 8'h78, 8'hC5, 8'h82, 8'hE0, 8'h8C, 8'h70,
                           8'hD2, 8'h3C, 8'h78, 8'hE9, 8'hFF, 8'h00, 8'h00, 8'h01};

  slink_crc_check dut (
    .clk       (clk),
    .reset     (reset),
    .pkt_start (pkt_start),
    .pkt_wc    (pkt_wc),
    .data_en   (data_en),
    .data_in   (data_in),
    .busy      (busy),
    .crc_done  (crc_done),
    .crc_err   (crc_err),
    .crc_calc  (crc_calc),
    .crc_rx    (crc_rx)
`ifdef SLINK_CRC_CHECK_ERR_CNT_EN
    ,
    .crc_err_count (crc_err_count)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [15:0] crc_model(input int wc);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 0; i < wc; i++) begin
      for (int k = 0; k < 8; k++) begin
        fb = c[0] ^ pay[i][k];
        c  = c >> 1;
        if (fb) c = c ^ 16'h8408;
      end
    end
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks (enter and leave on a negedge) ----------------
  task automatic start_pkt(input int wc);
    pkt_start = 1'b1;
    pkt_wc    = 16'(wc);
    data_en   = 1'b0;
    @(negedge clk);
    pkt_start = 1'b0;
  endtask

  task automatic send_body(input int wc, input logic [15:0] field, input logic stall,
                           input logic exp_err, input logic [15:0] exp_calc, input string name);
    logic [7:0]  b[$];
    logic [32:0] e;
    logic        early;
    int          nbeats;
    for (int i = 0; i < wc; i++) b.push_back(pay[i]);
    b.push_back(field[7:0]);
    b.push_back(field[15:8]);
    if (b.size() % 2 != 0) b.push_back(8'($urandom));
    nbeats = b.size() / 2;
    exp_q.push_back({exp_err, exp_calc, field});
    early = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      if (stall) begin
        repeat ($urandom_range(0, 2)) begin
          data_en = 1'b0;
          data_in = 16'($urandom);
          @(negedge clk);
          if (crc_done) early = 1'b1;
        end
      end
      data_en = 1'b1;
      data_in = {b[2*i+1], b[2*i]};
      @(negedge clk);
      if (i < nbeats - 1 && crc_done) early = 1'b1;
    end
    data_en = 1'b0;
    data_in = 16'($urandom);
    e = exp_q.pop_front();
    check({name, "_no_early_done"}, 32'(early), 32'd0);
    check({name, "_done"}, 32'(crc_done), 32'd1);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_err"}, 32'(crc_err), 32'(e[32]));
    check({name, "_calc"}, 32'(crc_calc), 32'(e[31:16]));
    check({name, "_rx"}, 32'(crc_rx), 32'(e[15:0]));
`ifdef SLINK_CRC_CHECK_ERR_CNT_EN
    if (e[32] && exp_cnt < 255) exp_cnt++;
    check({name, "_cnt"}, 32'(crc_err_count), 32'(exp_cnt));
`endif
    @(negedge clk);
    check({name, "_done_pulse"}, 32'(crc_done), 32'd0);
  endtask

  task automatic send_pkt(input int wc, input logic [15:0] field, input logic stall,
                          input logic exp_err, input logic [15:0] exp_calc, input string name);
    start_pkt(wc);
    check({name, "_busy_after_start"}, 32'(busy), 32'd1);
    send_body(wc, field, stall, exp_err, exp_calc, name);
  endtask

  // ---------------- test ----------------
  initial begin
    logic [15:0] c23, c1, c2;
    logic        seen;

    c23 = crc_model(23);
    c1  = crc_model(1);
    c2  = crc_model(2);
    vecs[0] = '{wc: 24, field: 16'hE569,     stall: 1'b0, exp_err: 1'b0, exp_calc: 16'hE569};
    vecs[1] = '{wc: 24, field: 16'hE568,     stall: 1'b0, exp_err: 1'b1, exp_calc: 16'hE569};
    vecs[2] = '{wc: 23, field: c23,          stall: 1'b0, exp_err: 1'b0, exp_calc: c23};
    vecs[3] = '{wc: 23, field: c23 ^ 16'h8000, stall: 1'b0, exp_err: 1'b1, exp_calc: c23};
    vecs[4] = '{wc: 0,  field: 16'hFFFF,     stall: 1'b0, exp_err: 1'b0, exp_calc: 16'hFFFF};
    vecs[5] = '{wc: 0,  field: 16'h0000,     stall: 1'b0, exp_err: 1'b1, exp_calc: 16'hFFFF};
    vecs[6] = '{wc: 1,  field: c1,           stall: 1'b0, exp_err: 1'b0, exp_calc: c1};
    vecs[7] = '{wc: 2,  field: c2,           stall: 1'b0, exp_err: 1'b0, exp_calc: c2};
    vecs[8] = '{wc: 24, field: 16'hE569,     stall: 1'b1, exp_err: 1'b0, exp_calc: 16'hE569};
    vecs[9] = '{wc: 23, field: c23,          stall: 1'b1, exp_err: 1'b0, exp_calc: c23};

    reset = 1'b1; pkt_start = 1'b0; pkt_wc = '0; data_en = 1'b0; data_in = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(crc_done), 32'd0);
    check("rst_err", 32'(crc_err), 32'd0);
    check("rst_calc", 32'(crc_calc), 32'hFFFF);
    check("rst_rx", 32'(crc_rx), 32'd0);
`ifdef SLINK_CRC_CHECK_ERR_CNT_EN
    check("rst_cnt", 32'(crc_err_count), 32'd0);
`endif
    reset = 1'b0;
    @(negedge clk);

    // data_en while idle must be ignored
    data_en = 1'b1; data_in = 16'h1234;
    repeat (3) @(negedge clk);
    data_en = 1'b0;
    check("idle_ignore_done", 32'(crc_done), 32'd0);
    check("idle_ignore_busy", 32'(busy), 32'd0);

    for (int v = 0; v < 10; v++) begin
      send_pkt(vecs[v].wc, vecs[v].field, vecs[v].stall, vecs[v].exp_err,
               vecs[v].exp_calc, $sformatf("vec%0d", v));
    end

    // abort mid-payload, then restart cleanly
    start_pkt(24);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      data_en = 1'b1;
      data_in = {pay[2*i+1], pay[2*i]};
      @(negedge clk);
      if (crc_done) seen = 1'b1;
    end
    data_en = 1'b0;
    check("abort_busy", 32'(busy), 32'd1);
    start_pkt(24);
    if (crc_done) seen = 1'b1;
    check("abort_no_done", 32'(seen), 32'd0);
    send_body(24, 16'hE569, 1'b0, 1'b0, 16'hE569, "after_abort");

    // pkt_start on the same cycle as the final CRC beat
    start_pkt(0);
    data_en = 1'b1; data_in = 16'h0000; pkt_start = 1'b1; pkt_wc = 16'd2;
    @(negedge clk);
    pkt_start = 1'b0; data_en = 1'b0;
    check("b2b_done", 32'(crc_done), 32'd1);
    check("b2b_err", 32'(crc_err), 32'd1);
    check("b2b_rx", 32'(crc_rx), 32'h0000);
    check("b2b_busy", 32'(busy), 32'd1);
`ifdef SLINK_CRC_CHECK_ERR_CNT_EN
    if (exp_cnt < 255) exp_cnt++;
`endif
    send_body(2, c2, 1'b0, 1'b0, c2, "b2b_second");

    // reset mid-payload
    start_pkt(24);
    for (int i = 0; i < 4; i++) begin
      data_en = 1'b1;
      data_in = {pay[2*i+1], pay[2*i]};
      @(negedge clk);
    end
    data_en = 1'b0;
    reset = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_calc", 32'(crc_calc), 32'hFFFF);
    check("midrst_done", 32'(crc_done), 32'd0);
`ifdef SLINK_CRC_CHECK_ERR_CNT_EN
    exp_cnt = 0;
    check("midrst_cnt", 32'(crc_err_count), 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_no_done", 32'(crc_done), 32'd0);
    send_pkt(23, c23, 1'b1, 1'b0, c23, "after_reset");

`ifdef SLINK_CRC_CHECK_ERR_CNT_EN
    for (int i = 0; i < 300; i++) begin
      send_pkt(0, 16'h0000, 1'b0, 1'b1, 16'hFFFF, $sformatf("sat%0d", i));
    end
    check("sat_final", 32'(crc_err_count), 32'hFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/slink_crc_check.md
Name: slink_crc_check

Overview:
- Receive-side CRC checker for S-Link long packets.
- Consumes the payload byte stream after the header is stripped, along with the packet word count (WC). Computes CRC-16/MCRF4XX over the payload and compares it with the trailing 2-byte CRC field, which is sent low byte first.
- Sits between the RX deskew/packet parser and the application interface.
- Reports pass/fail per packet.

Parameters:
- WC_W, 16, width of the payload byte count.
- ERR_CNT_W, 8, width of the saturating CRC error counter (optional feature only).

Ports:
- clk  in  1  link clock.
- reset  in  1  asynchronous, active-high reset.
- pkt_start  in  1  single-cycle pulse that opens a packet; pkt_wc is sampled with it; no data on this cycle.
- pkt_wc  in  WC_W  payload byte count, excluding the CRC bytes.
- data_en  in  1  data beat qualifier.
- data_in  in  16  beat data; byte0 in [7:0], byte1 in [15:8].
- busy  out  1  high from pkt_start until the final CRC byte is accepted.
- crc_done  out  1  single-cycle result strobe.
- crc_err  out  1  mismatch flag; valid with crc_done, held until the next crc_done.
- crc_calc  out  16  computed CRC; held.
- crc_rx  out  16  received CRC; held.
- crc_err_count  out  ERR_CNT_W  saturating error counter (optional feature only).

Behaviour:
- Reset values: busy=0, crc_done=0, crc_err=0, crc_calc=16'hFFFF, crc_rx=0, crc_err_count=0, FSM=IDLE, remaining-byte counter=0.
- CRC engine: a seed of 16'hFFFF is loaded on pkt_start. Each payload beat advances the engine by 2 bytes, or by 1 byte when only one payload byte remains. No final XOR is applied. Bit order matches CSI/DSI.
- FSM states:
  - IDLE: data_en is ignored. On pkt_start, latch rem=pkt_wc and seed the CRC. Go to PAYLOAD if pkt_wc>0, else to CRC.
  - PAYLOAD: on data_en, act on rem:
    - rem>2: feed 2 bytes; rem-=2.
    - rem==2: feed 2 bytes; go to CRC.
    - rem==1: feed [7:0] only; capture [15:8] as crc_rx[7:0]; go to CRC_HI.
  - CRC: on data_en, crc_rx={[15:8],[7:0]}; evaluate; go to IDLE.
  - CRC_HI: on data_en, crc_rx[15:8]=data_in[7:0]; data_in[15:8] is ignored; evaluate; go to IDLE.
- Evaluate: compare the registered CRC (all payload absorbed) against the received field. crc_done pulses, and crc_err/crc_calc/crc_rx update, in the cycle after the final CRC beat (latency 1). busy drops in the same cycle as crc_done.
- A beat without data_en is a stall: no state change.
- pkt_wc=0: expected CRC is 16'hFFFF; the first data beat is the CRC.
- pkt_start while busy: abort the current packet with no crc_done and no count change, then restart with the new pkt_wc.
- pkt_start in the same cycle as the final CRC beat: the result of the finishing packet is still reported (crc_done next cycle), and the new packet starts.
- The rem counter never wraps; pkt_wc=2^WC_W-1 is legal.
- Asserting reset mid-packet: FSM returns to IDLE immediately, outputs go to their reset values, and no result is produced.

Optional Feature:
- Macro SLINK_CRC_CHECK_ERR_CNT_EN.
- When defined: crc_err_count increments on every crc_done with crc_err=1 and saturates at all-ones. It clears only on reset.
- When undefined: the crc_err_count port and its counter logic are absent.

Decomposition:
- Shared package/include:
  - FSM state encodings: IDLE=2'd0, PAYLOAD=2'd1, CRC=2'd2, CRC_HI=2'd3.
  - CRC seed constant 16'hFFFF.
- One sub-module: instantiate the existing slink_crc_8_16bit_compute as the CRC engine:
  - valid=2'b11 for a 2-byte feed, 2'b01 for a 1-byte feed, 2'b00 otherwise.
  - init=pkt_start.
  - crc_prev = the engine's registered crc output.
- The checker owns the FSM, byte counter, CRC field capture, compare and counter.

Test Plan:
- pkt_wc=24, payload FF 00 00 00 1E F0 1E C7 4F 82 78 C5 82 E0 8C 70 D2 3C 78 E9 FF 00 00 01 in 12 beats, then beat 16'hE569 -> crc_done one cycle later, crc_err=0, crc_calc=crc_rx=16'hE569.
- Same payload with the final CRC beat 16'hE568 -> crc_err=1, crc_rx=16'hE568; crc_err_count 0->1 with the macro defined.
- pkt_wc=23 (first 23 bytes of the above), then an odd-straddle beat followed by a CRC_HI beat -> the CRC low byte is taken from [15:8] of beat 12 and the high byte from [7:0] of beat 13; result matches the software model; data_in[15:8] of the last beat is ignored.
- pkt_wc=0, then a single beat 16'hFFFF -> crc_err=0. Repeat with 16'h0000 -> crc_err=1.
- Corner cases:
  - Random data_en stalls: same result as without stalls.
  - pkt_start issued mid-payload: no crc_done for the aborted packet; the new packet checks correctly.
  - reset asserted mid-PAYLOAD: busy=0 immediately.
- With the macro defined, 300 consecutive bad packets -> crc_err_count saturates at 8'hFF.
